pbit_node_seq: RTL and testbench

Next-generation Boltzmann probabilistic-bit node, fully digital and parametrised in neighbour count and fixed-point format. It computes the local field (bias + Σ weight_i·neighbour_i) with a sequential one-neighbour-per-cycle MAC. It then applies an inverse-temperature shift and a hard-sigmoid to form a flip probability, and samples it against an internal 16-bit LFSR. An optional deterministic mode (node = field ≥ 0) is provided. Instances tile into the Boltzmann lattice, sequenced by a start/done handshake.

---
 rtl/pbit_pkg.sv | 31 +++
 rtl/pbit_node_seq_lfsr.sv | 25 ++
 rtl/pbit_node_seq.sv | 115 +++++++++++
 tb/tb_pbit_node_seq.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pbit_pkg.sv
// Shared types and fixed-point helpers for the probabilistic-bit node.
package pbit_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SCALE, SAMPLE} state_t;

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Clamp a signed value into the two's-complement range of a w-bit word.
  function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                      input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // 0.5 + x/4 clamped to [0,1], returned as a 16-bit probability; exactly 1.0 maps to 0xFFFF.
  function automatic logic [15:0] hard_sigmoid(input logic signed [63:0] x, input int frac);
    logic signed [63:0] one;
    logic signed [63:0] p;
    one = 64'sd1 <<< frac;
    p   = (one >>> 1) + (x >>> 2);
    if (p <= 64'sd0) return 16'h0000;
    if (p >= one) return 16'hFFFF;
    return 16'(p <<< (16 - frac));
  endfunction

endpackage

// File: rtl/pbit_node_seq_lfsr.sv
// 16-bit right-shifting Galois LFSR; load beats step, a zero seed falls back to SEED.
module pbit_lfsr16
  import pbit_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        load,
  input  logic [15:0] seed,
  output logic [15:0] rnd
);

  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= SEED;
    end else if (load) begin
      rnd <= (seed == 16'h0000) ? SEED : seed;
    end else if (step) begin
      rnd <= (rnd >> 1) ^ (rnd[0] ? LFSR_TAPS : 16'h0000);
    end
  end

endmodule

// File: rtl/pbit_node_seq.sv
// Probabilistic-bit node: serial MAC of the local field, beta scaling, hard sigmoid, LFSR sample.
// start accepted only in IDLE; done pulses N_NEIGH+2 cycles after acceptance, starts while busy are dropped.
module pbit_node_seq
  import pbit_pkg::*;
#(
  parameter int          WIDTH     = 16,
  parameter int          FRAC      = 12,
  parameter int          N_NEIGH   = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       det_mode,
  input  logic [2:0]                 beta_shift,
  input  logic [N_NEIGH-1:0]         neighbours,
  input  logic [N_NEIGH*WIDTH-1:0]   weights,
  input  logic signed [WIDTH-1:0]    bias,
  input  logic                       seed_we,
  input  logic [15:0]                seed_in,
  output logic                       busy,
  output logic                       done,
  output logic                       node,
  output logic [15:0]                prob,
  output logic signed [WIDTH-1:0]    field
);

  localparam int AW = WIDTH + $clog2(N_NEIGH) + 1;
  localparam int IW = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;

  state_t                    state;
  logic signed [AW-1:0]      acc;
  logic [IW-1:0]             idx;
  logic [N_NEIGH-1:0]        neigh_q;
  logic [N_NEIGH*WIDTH-1:0]  weights_q;
  logic [2:0]                beta_q;
  logic                      det_q;

  logic [15:0]               rnd;
  logic                      lfsr_step;
  logic                      lfsr_load;
  logic signed [WIDTH-1:0]   w_cur;
  logic signed [63:0]        acc_ext;
  logic signed [63:0]        f_sat;
  logic signed [63:0]        x_sat;

  assign w_cur   = weights_q[int'(idx) * WIDTH +: WIDTH];
  assign acc_ext = 64'(acc);
  assign f_sat   = sat_to_width(acc_ext, WIDTH);
  assign x_sat   = sat_to_width(f_sat <<< beta_q, WIDTH);

  // The random draw is consumed only by stochastic samples; seeding yields to start.
  assign lfsr_step = (state == SAMPLE) && !det_q;
  assign lfsr_load = (state == IDLE) && seed_we && !start;

  pbit_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (lfsr_step),
    .load (lfsr_load),
    .seed (seed_in),
    .rnd  (rnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      idx       <= '0;
      neigh_q   <= '0;
      weights_q <= '0;
      beta_q    <= '0;
      det_q     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      node      <= 1'b0;
      prob      <= 16'h0000;
      field     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc       <= AW'(bias);
            idx       <= '0;
            neigh_q   <= neighbours;
            weights_q <= weights;
            beta_q    <= beta_shift;
            det_q     <= det_mode;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end
        ACCUM: begin
          if (neigh_q[idx]) acc <= acc + AW'(w_cur);
          idx <= idx + 1'b1;
          if (idx == IW'(N_NEIGH - 1)) state <= SCALE;
        end
        SCALE: begin
          field <= x_sat[WIDTH-1:0];
          prob  <= hard_sigmoid(x_sat, FRAC);
          state <= SAMPLE;
        end
        SAMPLE: begin
          node  <= det_q ? ~field[WIDTH-1] : (rnd <= prob);
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pbit_node_seq.sv
// Directed and randomized checks of pbit_node_seq against an arithmetic reference model.
module tb_pbit_node_seq;
  import pbit_pkg::*;

  localparam int N = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           det_mode;
  logic [2:0]     beta_shift;
  logic [N-1:0]   neighbours;
  logic [N*W-1:0] weights;
  logic [W-1:0]   bias;
  logic           seed_we;
  logic [15:0]    seed_in;
  logic           busy;
  logic           done;
  logic           node;
  logic [15:0]    prob;
  logic [W-1:0]   field;

  int tests = 0;
  int fails = 0;
  logic [15:0] m_lfsr;

  always #5 clk = ~clk;

  pbit_node_seq #(.WIDTH(W), .FRAC(12), .N_NEIGH(N), .LFSR_SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .det_mode   (det_mode),
    .beta_shift (beta_shift),
    .neighbours (neighbours),
    .weights    (weights),
    .bias       (bias),
    .seed_we    (seed_we),
    .seed_in    (seed_in),
    .busy       (busy),
    .done       (done),
    .node       (node),
    .prob       (prob),
    .field      (field)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic longint clamp16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic logic [N*W-1:0] all_weights(input logic [15:0] w);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = w;
    return r;
  endfunction

  // One full update: model prediction, handshake, latency and result checks.
  task automatic run_update(input logic det, input logic [2:0] beta, input logic [N-1:0] nb,
                            input logic [N*W-1:0] w, input logic [15:0] b, input bit disturb,
                            output logic got);
    longint sum, f, x, p;
    logic [15:0] ep;
    logic        en;
    int          cyc;
    sum = longint'($signed(b));
    for (int i = 0; i < N; i++)
      if (nb[i]) sum += longint'($signed(w[i*W +: W]));
    f = clamp16(sum);
    x = clamp16(f * (longint'(1) << beta));
    p = 2048 + (x >>> 2);
    if (p >= 4096) ep = 16'hFFFF;
    else if (p <= 0) ep = 16'h0000;
    else ep = 16'(p * 16);
    en = det ? (x >= 0) : (m_lfsr <= ep);

    @(negedge clk);
    det_mode = det; beta_shift = beta; neighbours = nb; weights = w; bias = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seed_we = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      if (disturb && cyc == 3) begin
        weights = ~weights; bias = ~bias; neighbours = ~neighbours;
        beta_shift = ~beta_shift; det_mode = ~det_mode;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_latency", cyc, N + 2);
    check("busy_at_done", {31'b0, busy}, 32'd0);
    check("field", {16'b0, field}, {16'b0, 16'(x)});
    check("prob", {16'b0, prob}, {16'b0, ep});
    check("node", {31'b0, node}, {31'b0, en});
    if (!det) m_lfsr = lfsr_next(m_lfsr);
    got = node;
    @(posedge clk); #1;
    check("done_one_cycle", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic           n;
    int             ones;
    int             extra;
    int             cyc;
    logic [N*W-1:0] rw;

    rst = 1'b1; start = 1'b0; det_mode = 1'b0; beta_shift = 3'd0; neighbours = '0;
    weights = '0; bias = '0; seed_we = 1'b0; seed_in = 16'h0;
    m_lfsr = 16'hACE1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_node", {31'b0, node}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_prob", {16'b0, prob}, 32'd0);
    check("rst_field", {16'b0, field}, 32'd0);
    check("rst_lfsr", {16'b0, dut.u_lfsr.rnd}, 32'h0000ACE1);
    @(negedge clk); rst = 1'b0;

    // Zero field: prob exactly one half, node fraction near 0.5.
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      run_update(1'b0, 3'd0, N'($urandom), '0, 16'h0000, 1'b0, n);
      ones += int'(n);
    end
    check("zero_prob", {16'b0, prob}, 32'h00008000);
    check("zero_field", {16'b0, field}, 32'd0);
    check("zero_fraction", {31'b0, (ones >= 1926 && ones <= 2170)}, 32'd1);

    ones = 0;
    for (int k = 0; k < 200; k++) begin
      run_update(1'b0, 3'd0, N'($urandom), '0, 16'h4000, 1'b0, n);
      ones += int'(n);
    end
    check("clamp_hi_prob", {16'b0, prob}, 32'h0000FFFF);
    check("clamp_hi_ones", ones, 200);
    ones = 0;
    for (int k = 0; k < 200; k++) begin
      run_update(1'b0, 3'd0, N'($urandom), '0, 16'hC000, 1'b0, n);
      ones += int'(n);
    end
    check("clamp_lo_prob", {16'b0, prob}, 32'd0);
    check("clamp_lo_ones", ones, 0);

    run_update(1'b0, 3'd0, 8'hFF, all_weights(16'h7FFF), 16'h7FFF, 1'b0, n);
    check("sat_pos_field", {16'b0, field}, 32'h00007FFF);
    check("sat_pos_prob", {16'b0, prob}, 32'h0000FFFF);
    run_update(1'b0, 3'd0, 8'hFF, all_weights(16'h8000), 16'h0000, 1'b0, n);
    check("sat_neg_field", {16'b0, field}, 32'h00008000);
    check("sat_neg_prob", {16'b0, prob}, 32'd0);

    run_update(1'b0, 3'd3, 8'h00, '0, 16'h0100, 1'b0, n);
    check("beta_field", {16'b0, field}, 32'h00000800);
    check("beta_prob", {16'b0, prob}, 32'h0000A000);

    run_update(1'b1, 3'd0, 8'h00, '0, 16'hFFFF, 1'b0, n);
    check("det_neg_node", {31'b0, node}, 32'd0);
    check("det_lfsr_hold", {16'b0, dut.u_lfsr.rnd}, {16'b0, m_lfsr});

    // start held through busy: one accepted update, nothing queued.
    @(negedge clk);
    det_mode = 1'b1; beta_shift = 3'd0; neighbours = '0; weights = '0; bias = 16'h0000;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check("hold_latency", cyc, N + 2);
    check("det_zero_node", {31'b0, node}, 32'd1);
    extra = 0;
    repeat (14) begin
      @(posedge clk); #1;
      extra += int'(done);
    end
    check("hold_single_done", extra, 0);

    run_update(1'b0, 3'd1, 8'hA5, all_weights(16'h0123), 16'hFE00, 1'b1, n);

    @(negedge clk); seed_we = 1'b1; seed_in = 16'h0000;
    @(posedge clk); #1; seed_we = 1'b0; m_lfsr = 16'hACE1;
    check("seed_zero", {16'b0, dut.u_lfsr.rnd}, 32'h0000ACE1);
    @(negedge clk); seed_we = 1'b1; seed_in = 16'h1234;
    @(posedge clk); #1; seed_we = 1'b0; m_lfsr = 16'h1234;
    check("seed_load", {16'b0, dut.u_lfsr.rnd}, 32'h00001234);
    seed_we = 1'b1; seed_in = 16'h5555;
    run_update(1'b0, 3'd0, 8'h0F, all_weights(16'h0400), 16'h0000, 1'b0, n);
    check("seed_vs_start", {16'b0, dut.u_lfsr.rnd}, {16'b0, m_lfsr});

    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < N; i++) rw[i*W +: W] = 16'($urandom);
      run_update(1'($urandom), 3'($urandom), N'($urandom), rw, 16'($urandom), k[0], n);
    end
    check("rand_lfsr", {16'b0, dut.u_lfsr.rnd}, {16'b0, m_lfsr});

    // Reset in the middle of accumulation.
    @(negedge clk);
    det_mode = 1'b0; neighbours = 8'hFF; weights = all_weights(16'h0100); bias = 16'h0100;
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_state", {30'b0, dut.state}, {30'b0, IDLE});
    check("mid_rst_prob", {16'b0, prob}, 32'd0);
    @(negedge clk); rst = 1'b0; m_lfsr = 16'hACE1;
    extra = 0;
    repeat (15) begin
      @(posedge clk); #1;
      extra += int'(done);
    end
    check("mid_rst_no_done", extra, 0);
    run_update(1'b0, 3'd2, 8'h3C, all_weights(16'hF800), 16'h0200, 1'b0, n);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
